// File: rtl/alu_pkg.sv
// Shared constants and types for the LC-3 datapath ALU and its condition-code logic.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [2:0] NZP_N     = 3'b100;
    localparam logic [2:0] NZP_Z     = 3'b010;
    localparam logic [2:0] NZP_P     = 3'b001;
    localparam logic [2:0] NZP_RESET = NZP_Z;

    typedef enum logic [1:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_AND,
        ALU_NOT
    } alu_op_e;

    // Anything outside the three operate opcodes leaves the result registers untouched.
    function automatic alu_op_e decode_op(input logic [3:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_AND:  return ALU_AND;
            OP_NOT:  return ALU_NOT;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_nzp_gen.sv
// Combinational one-hot N/Z/P generator for a two's-complement value.
// Shared by the ALU and the load-path condition-code logic.
module alu_nzp_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [2:0]       o_nzp
);

    logic w_is_neg;
    logic w_is_zero;

    assign w_is_neg  = i_value[WIDTH-1];
    assign w_is_zero = (i_value == '0);

    // Sign test first so the result is always exactly one-hot.
    assign o_nzp = w_is_neg  ? NZP_N :
                   w_is_zero ? NZP_Z :
                               NZP_P;

endmodule

// File: rtl/alu.sv
// LC-3 ADD/AND/NOT ALU with registered result and one-hot condition code.
// Define ALU_OVF_EN to add a registered signed-overflow output (ovf).
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       nzp
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    alu_op_e          w_op;
    logic [WIDTH-1:0] w_result;
    logic             w_load;
    logic [2:0]       w_nzp;

    logic [WIDTH-1:0] r_out;
    logic [2:0]       r_nzp;

    assign w_op = decode_op(opcode);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        w_result = '0;
        w_load   = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_result = a + b;
                w_load   = 1'b1;
            end
            ALU_AND: begin
                w_result = a & b;
                w_load   = 1'b1;
            end
            ALU_NOT: begin
                w_result = ~a;
                w_load   = 1'b1;
            end
            default: begin
                w_result = '0;
                w_load   = 1'b0;
            end
        endcase
    end

    alu_nzp_gen #(
        .WIDTH (WIDTH)
    ) u_nzp_gen (
        .i_value (w_result),
        .o_nzp   (w_nzp)
    );

    // NOTE: state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_nzp <= NZP_RESET;
        end else if (w_load) begin
            r_out <= w_result;
            r_nzp <= w_nzp;
        end
    end

    assign out = r_out;
    assign nzp = r_nzp;

`ifdef ALU_OVF_EN
    logic w_add_ovf;
    logic r_ovf;

    // Same-sign operands producing a result of the other sign.
    assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_result[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_ovf <= (w_op == ALU_ADD) ? w_add_ovf : 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the LC-3 ALU: directed cases plus randomized traffic vs a reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  opcode;
    logic [15:0] out;
    logic [2:0]  nzp;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_out;
    logic [2:0]  exp_nzp;
    logic        exp_ovf;

    alu #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .out    (out),
        .nzp    (nzp)
`ifdef ALU_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic on the operation's meaning.
    task automatic model_reset();
        exp_out = 16'h0000;
        exp_nzp = 3'b010;
        exp_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] ma, input logic [15:0] mb, input logic [3:0] mop);
        int ua, ub, sa, sb, ssum, res, sres;
        bit upd;
        ua  = int'(ma);
        ub  = int'(mb);
        sa  = (ua >= 32768) ? ua - 65536 : ua;
        sb  = (ub >= 32768) ? ub - 65536 : ub;
        upd = 1'b1;
        res = 0;
        if (mop == 4'd1) begin
            res     = (ua + ub) % 65536;
            ssum    = sa + sb;
            exp_ovf = (ssum > 32767) || (ssum < -32768);
        end else if (mop == 4'd5) begin
            res     = int'(ma & mb);
            exp_ovf = 1'b0;
        end else if (mop == 4'd9) begin
            res     = 65535 - ua;
            exp_ovf = 1'b0;
        end else begin
            upd = 1'b0;
        end
        if (upd) begin
            exp_out = res[15:0];
            sres    = (res >= 32768) ? res - 65536 : res;
            if (sres < 0)       exp_nzp = 3'b100;
            else if (sres == 0) exp_nzp = 3'b010;
            else                exp_nzp = 3'b001;
        end
    endtask

    // Drive operands mid-cycle, clock them in, then sample just after the edge.
    task automatic apply(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] top);
        @(negedge clk);
        a      = ta;
        b      = tb;
        opcode = top;
        @(posedge clk);
        #1;
        model_step(ta, tb, top);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        a      = 16'd5;
        b      = 16'd3;
        opcode = 4'b0001;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out, nzp} !== {16'h0000, 3'b010}) begin
            errors++;
            $display("FAIL reset_hold: out=%h nzp=%b expected out=0000 nzp=010", out, nzp);
        end
`ifdef ALU_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b expected 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_step(16'd5, 16'd3, 4'b0001);
        checks++;
        if ({out, nzp} !== {16'd8, 3'b001}) begin
            errors++;
            $display("FAIL reset_release: out=%h nzp=%b expected out=0008 nzp=001", out, nzp);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [9];
        logic [15:0] vb [9];
        logic [3:0]  vo [9];
        logic [15:0] ro [9];
        logic [2:0]  rn [9];
        logic        rv [9];
        va = '{16'd5,    16'd5,    16'hF0F0, 16'hFFFD, 16'd2,    16'hFFFD, 16'd1,    16'hFFFF, 16'hFFFF};
        vb = '{16'd3,    16'd4,    16'h0F0F, 16'h0000, 16'hFFFE, 16'hFFFC, 16'd1,    16'd1,    16'h1234};
        vo = '{4'b0001,  4'b0101,  4'b0101,  4'b1001,  4'b0001,  4'b0001,  4'b0001,  4'b0001,  4'b1001};
        ro = '{16'd8,    16'd4,    16'h0000, 16'd2,    16'h0000, 16'hFFF9, 16'd2,    16'h0000, 16'h0000};
        rn = '{3'b001,   3'b001,   3'b010,   3'b001,   3'b010,   3'b100,   3'b001,   3'b010,   3'b010};
        rv = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0};
        for (int i = 0; i < 9; i++) begin
            apply(va[i], vb[i], vo[i]);
            checks++;
            if ({out, nzp} !== {ro[i], rn[i]} || {out, nzp} !== {exp_out, exp_nzp}) begin
                errors++;
                $display("FAIL directed_%0d: out=%h nzp=%b expected out=%h nzp=%b", i, out, nzp, ro[i], rn[i]);
            end
`ifdef ALU_OVF_EN
            checks++;
            if (ovf !== rv[i]) begin
                errors++;
                $display("FAIL directed_ovf_%0d: ovf=%b expected %b", i, ovf, rv[i]);
            end
`endif
        end
    endtask

    task automatic test_hold_wrap();
        apply(16'd5, 16'd3, 4'b0001);
        apply(16'd1, 16'd1, 4'b0000);
        checks++;
        if ({out, nzp} !== {16'd8, 3'b001}) begin
            errors++;
            $display("FAIL hold_op0: out=%h nzp=%b expected out=0008 nzp=001", out, nzp);
        end
        apply(16'h7FFF, 16'd1, 4'b0001);
        checks++;
        if ({out, nzp} !== {16'h8000, 3'b100}) begin
            errors++;
            $display("FAIL wrap_7fff: out=%h nzp=%b expected out=8000 nzp=100", out, nzp);
        end
`ifdef ALU_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ovf: ovf=%b expected 1", ovf);
        end
`endif
        apply(16'h0000, 16'h0000, 4'b1111);
        checks++;
        if ({out, nzp} !== {16'h8000, 3'b100}) begin
            errors++;
            $display("FAIL hold_op15: out=%h nzp=%b expected out=8000 nzp=100", out, nzp);
        end
`ifdef ALU_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL hold_ovf: ovf=%b expected 1", ovf);
        end
`endif
    endtask

    task automatic test_async_reset();
        apply(16'd5, 16'd3, 4'b0001);
        @(negedge clk);
        a      = 16'h1234;
        b      = 16'h0001;
        opcode = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out, nzp} !== {16'h0000, 3'b010}) begin
            errors++;
            $display("FAIL async_reset: out=%h nzp=%b expected out=0000 nzp=010", out, nzp);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out, nzp} !== {16'h0000, 3'b010}) begin
            errors++;
            $display("FAIL reset_overrides: out=%h nzp=%b expected out=0000 nzp=010", out, nzp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0]  ops [6];
        logic [15:0] ra, rb;
        logic [3:0]  rop;
        ops = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b0011, 4'b1101};
        for (int i = 0; i < 300; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            if ($urandom_range(0, 9) == 0) rb = 16'(0) - ra;
            rop = ops[$urandom_range(0, 5)];
            apply(ra, rb, rop);
            checks++;
            if ({out, nzp} !== {exp_out, exp_nzp} || !$onehot(nzp)) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h op=%b out=%h nzp=%b expected out=%h nzp=%b",
                         i, ra, rb, rop, out, nzp, exp_out, exp_nzp);
            end
`ifdef ALU_OVF_EN
            checks++;
            if (ovf !== exp_ovf) begin
                errors++;
                $display("FAIL random_ovf_%0d: a=%h b=%h op=%b ovf=%b expected %b", i, ra, rb, rop, ovf, exp_ovf);
            end
`endif
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        opcode = '0;
        model_reset();
        test_reset();
        test_directed();
        test_hold_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
